dac_sample_scheduler: RTL and testbench
=======================================

DAC_SAMPLE_SCHEDULER -- requirements
Module: dac_sample_scheduler

Interface
REQ-001 SHALL have parameter CODE_WIDTH, default 10; the width of every sample code.
REQ-002 SHALL have parameter UF_WIDTH, default 16; the width of the underflow counter.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mode  input  2  source policy: 0=A only, 1=B only, 2=alternate, 3=mix.
REQ-006 next_sample  input  1  one-cycle pulse from the PWM DAC, asserted one cycle before its window restarts.
REQ-007 a_code  input  CODE_WIDTH  sample from requester A.
REQ-008 a_valid  input  1  requester A sample is offered.
REQ-009 a_ready  output  1  the scheduler can accept an A sample.
REQ-010 b_code, b_valid, b_ready  SHALL be identical to the A ports, but for requester B.
REQ-011 code  output  CODE_WIDTH  registered code driven to the DAC.
REQ-012 code_update  output  1  one-cycle pulse; code was loaded this cycle.
REQ-013 underflow  output  1  one-cycle pulse; a window had no eligible sample.
REQ-014 underflow_count  output  UF_WIDTH  saturating count of underflow events.

Function
REQ-015 SHALL hold one single-entry slot per requester (data register plus full flag).
REQ-016 SHALL drive a_ready = !a_full && !rst combinationally; b_ready likewise. There is no bypass: a full slot never accepts data, even in its consume cycle.
REQ-017 SHALL transfer on a_valid && a_ready at a clock edge: a_slot <= a_code, a_full <= 1. B behaves the same way.
REQ-018 SHALL sample mode only in cycles where next_sample=1. A mode change in any other cycle SHALL have no effect until the next next_sample.
REQ-019 SHALL take every decision in the next_sample cycle. code, code_update and underflow SHALL become visible the following cycle, so a new code applies from DAC count 0 of the new window.
REQ-020 Mode 0: if a_full, SHALL load code <= a_slot and clear a_full; otherwise SHALL hold code and flag underflow. The B slot is untouched.
REQ-021 Mode 1: SHALL behave like mode 0, with A and B swapped.
REQ-022 Mode 2: SHALL keep an internal turn bit (reset 0 = A). The source named by turn is served if full. Otherwise the other source is served if full. Otherwise underflow. turn SHALL toggle on every next_sample in mode 2, whether or not a sample was served.
REQ-023 Mode 3: if both slots are full, SHALL load code <= (a_slot + b_slot) >> 1, computed at CODE_WIDTH+1 bits with no overflow, and clear both slots. Otherwise SHALL consume neither slot, hold code, and flag underflow.
REQ-024 SHALL pulse code_update high for exactly one cycle per load. code_update and underflow SHALL never both be high.
REQ-025 SHALL increment underflow_count by 1 per underflow pulse and saturate at all-ones.
REQ-026 SHALL ignore next_sample while rst=1.
REQ-027 When next_sample coincides with a valid handshake on an empty slot, SHALL both fill the slot and treat the slot as empty for this decision. The new sample is served no earlier than the next window.

Reset
REQ-028 rst=1 SHALL, at the next edge, set code=0, both slots empty, turn=0, code_update=0, underflow=0, underflow_count=0.
REQ-029 Assertion of rst mid-window SHALL discard buffered samples without emitting them. Operation SHALL resume on the first next_sample after rst deasserts.
REQ-030 a_ready and b_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-031 Mode 0: A offers 0x155, then pulse next_sample -> next cycle code=0x155, code_update=1, a_ready=1 again; B offers 0x0AA and remains stalled in its slot with b_ready=0.
REQ-032 Mode 3: A=0x3FF and B=0x3FE both full, then pulse next_sample -> code=0x3FE (1023+1022=2045, >>1). Then only A full at the next pulse -> underflow=1, code stays 0x3FE, A slot is retained.
REQ-033 Mode 2: keep both slots refilled across 4 pulses -> sources served in order A,B,A,B. With only B supplying -> every pulse serves B with no underflow.
REQ-034 Mode 1 with no B data: apply 65537 next_sample pulses -> underflow_count=0xFFFF, saturated, and code is unchanged from its prior value.
REQ-035 Fill both slots, assert rst for 1 cycle mid-window, then pulse next_sample -> code=0, underflow=1, a_ready=b_ready=1.
REQ-036 Change mode from 0 to 1 two cycles after a next_sample -> the following pulse applies mode 1; the pulse before the change applied mode 0.

Source files
------------

// File: rtl/dac_sample_scheduler_if.sv
// Sample handshake and DAC output bundle for dac_sample_scheduler.
// The master side feeds requester samples and the window strobe; the slave side is the scheduler.
interface dac_sample_scheduler_if #(
  parameter int CODE_WIDTH = 10,
  parameter int UF_WIDTH   = 16
);
  logic [1:0]            mode;
  logic                  next_sample;
  logic [CODE_WIDTH-1:0] a_code;
  logic                  a_valid;
  logic                  a_ready;
  logic [CODE_WIDTH-1:0] b_code;
  logic                  b_valid;
  logic                  b_ready;
  logic [CODE_WIDTH-1:0] code;
  logic                  code_update;
  logic                  underflow;
  logic [UF_WIDTH-1:0]   underflow_count;

  modport master (
    output mode, next_sample, a_code, a_valid, b_code, b_valid,
    input  a_ready, b_ready, code, code_update, underflow, underflow_count
  );

  modport slave (
    input  mode, next_sample, a_code, a_valid, b_code, b_valid,
    output a_ready, b_ready, code, code_update, underflow, underflow_count
  );
endinterface

// File: rtl/dac_sample_scheduler.sv
// Picks the next PWM DAC code from two single-entry requester slots once per window.
// The choice is made on the next_sample strobe and is presented one cycle later.
module dac_sample_scheduler #(
  parameter int CODE_WIDTH = 10,
  parameter int UF_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  dac_sample_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_A   = 2'd0,
    MODE_B   = 2'd1,
    MODE_ALT = 2'd2,
    MODE_MIX = 2'd3
  } mode_e;

  logic [CODE_WIDTH-1:0] a_slot, b_slot;
  logic                  a_full, b_full;
  logic                  turn;
  logic [CODE_WIDTH-1:0] code_q, code_d;
  logic                  code_update_q, underflow_q;
  logic [UF_WIDTH-1:0]   uf_count;
  logic                  take_a, take_b, load, starve;
  logic [CODE_WIDTH:0]   mix_sum;
  mode_e                 mode_sel;

  assign mode_sel = mode_e'(bus.mode);
  assign mix_sum  = {1'b0, a_slot} + {1'b0, b_slot};

  // No bypass: a slot only accepts while empty, so a fill and a consume never collide.
  assign bus.a_ready         = !a_full && !rst;
  assign bus.b_ready         = !b_full && !rst;
  assign bus.code            = code_q;
  assign bus.code_update     = code_update_q;
  assign bus.underflow       = underflow_q;
  assign bus.underflow_count = uf_count;

  always_comb begin
    take_a = 1'b0;
    take_b = 1'b0;
    load   = 1'b0;
    starve = 1'b0;
    code_d = code_q;
    if (bus.next_sample) begin
      unique case (mode_sel)
        MODE_A: begin
          if (a_full) begin take_a = 1'b1; load = 1'b1; code_d = a_slot; end
          else starve = 1'b1;
        end
        MODE_B: begin
          if (b_full) begin take_b = 1'b1; load = 1'b1; code_d = b_slot; end
          else starve = 1'b1;
        end
        MODE_ALT: begin
          // The favoured source yields to the other one when it has nothing queued.
          if (!turn) begin
            if (a_full)      begin take_a = 1'b1; load = 1'b1; code_d = a_slot; end
            else if (b_full) begin take_b = 1'b1; load = 1'b1; code_d = b_slot; end
            else starve = 1'b1;
          end else begin
            if (b_full)      begin take_b = 1'b1; load = 1'b1; code_d = b_slot; end
            else if (a_full) begin take_a = 1'b1; load = 1'b1; code_d = a_slot; end
            else starve = 1'b1;
          end
        end
        MODE_MIX: begin
          if (a_full && b_full) begin
            take_a = 1'b1;
            take_b = 1'b1;
            load   = 1'b1;
            code_d = CODE_WIDTH'(mix_sum >> 1);
          end else starve = 1'b1;
        end
        default: starve = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_full        <= 1'b0;
      b_full        <= 1'b0;
      turn          <= 1'b0;
      code_q        <= '0;
      code_update_q <= 1'b0;
      underflow_q   <= 1'b0;
      uf_count      <= '0;
    end else begin
      if (bus.a_valid && bus.a_ready) begin
        a_slot <= bus.a_code;
        a_full <= 1'b1;
      end else if (take_a) begin
        a_full <= 1'b0;
      end
      if (bus.b_valid && bus.b_ready) begin
        b_slot <= bus.b_code;
        b_full <= 1'b1;
      end else if (take_b) begin
        b_full <= 1'b0;
      end
      if (bus.next_sample && mode_sel == MODE_ALT) turn <= !turn;
      code_q        <= code_d;
      code_update_q <= load;
      underflow_q   <= starve;
      if (starve && uf_count != '1) uf_count <= uf_count + UF_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed self-checking bench for dac_sample_scheduler.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_dac_sample_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dac_sample_scheduler_if #(.CODE_WIDTH(10), .UF_WIDTH(16)) bus ();

  dac_sample_scheduler #(.CODE_WIDTH(10), .UF_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic offer_a(input logic [9:0] value);
    bus.a_code  = value;
    bus.a_valid = 1'b1;
    tick();
    bus.a_valid = 1'b0;
  endtask

  task automatic offer_b(input logic [9:0] value);
    bus.b_code  = value;
    bus.b_valid = 1'b1;
    tick();
    bus.b_valid = 1'b0;
  endtask

  task automatic pulse();
    bus.next_sample = 1'b1;
    tick();
    bus.next_sample = 1'b0;
  endtask

  task automatic expect_load(input string tag, input logic [9:0] value);
    check_output({tag, "_code"}, 32'(bus.code), 32'(value));
    check_output({tag, "_upd"},  32'(bus.code_update), 32'd1);
    check_output({tag, "_uf"},   32'(bus.underflow), 32'd0);
  endtask

  task automatic expect_starve(input string tag, input logic [9:0] value);
    check_output({tag, "_code"}, 32'(bus.code), 32'(value));
    check_output({tag, "_upd"},  32'(bus.code_update), 32'd0);
    check_output({tag, "_uf"},   32'(bus.underflow), 32'd1);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.mode        = 2'd0;
    bus.next_sample = 1'b0;
    bus.a_code      = '0;
    bus.a_valid     = 1'b0;
    bus.b_code      = '0;
    bus.b_valid     = 1'b0;

    // Reset state
    tick();
    tick();
    check_output("rst_code",    32'(bus.code), 32'd0);
    check_output("rst_upd",     32'(bus.code_update), 32'd0);
    check_output("rst_uf",      32'(bus.underflow), 32'd0);
    check_output("rst_ufcount", 32'(bus.underflow_count), 32'd0);
    check_output("rst_aready",  32'(bus.a_ready), 32'd0);
    check_output("rst_bready",  32'(bus.b_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_output("post_rst_aready", 32'(bus.a_ready), 32'd1);
    check_output("post_rst_bready", 32'(bus.b_ready), 32'd1);

    // Mode 0 serves A, B stays parked
    offer_a(10'h155);
    offer_b(10'h0AA);
    check_output("m0_a_full", 32'(bus.a_ready), 32'd0);
    check_output("m0_b_full", 32'(bus.b_ready), 32'd0);
    pulse();
    expect_load("m0_load", 10'h155);
    check_output("m0_aready_again", 32'(bus.a_ready), 32'd1);
    check_output("m0_b_stalled",    32'(bus.b_ready), 32'd0);
    tick();
    check_output("m0_upd_one_cycle", 32'(bus.code_update), 32'd0);

    // Mode 0 with only B queued underflows; a mid-window switch to mode 1 waits for the strobe
    pulse();
    expect_starve("m0_starve", 10'h155);
    check_output("m0_ufcount", 32'(bus.underflow_count), 32'd1);
    tick();
    bus.mode = 2'd1;
    tick();
    check_output("m1_no_early", 32'(bus.code_update), 32'd0);
    pulse();
    expect_load("m1_load", 10'h0AA);
    check_output("m1_bready", 32'(bus.b_ready), 32'd1);

    // Mode 3 averages at CODE_WIDTH+1 bits
    bus.mode = 2'd3;
    offer_a(10'h3FF);
    offer_b(10'h3FE);
    pulse();
    expect_load("m3_mix", 10'h3FE);
    check_output("m3_aready", 32'(bus.a_ready), 32'd1);
    check_output("m3_bready", 32'(bus.b_ready), 32'd1);
    offer_a(10'h001);
    pulse();
    expect_starve("m3_half", 10'h3FE);
    check_output("m3_a_kept",   32'(bus.a_ready), 32'd0);
    check_output("m3_ufcount",  32'(bus.underflow_count), 32'd2);
    offer_b(10'h100);
    pulse();
    expect_load("m3_mix2", 10'h080);

    // Fill coinciding with the strobe is not served this window
    bus.mode        = 2'd0;
    bus.a_code      = 10'h0F0;
    bus.a_valid     = 1'b1;
    bus.next_sample = 1'b1;
    tick();
    bus.a_valid     = 1'b0;
    bus.next_sample = 1'b0;
    expect_starve("coinc_starve", 10'h080);
    check_output("coinc_filled",  32'(bus.a_ready), 32'd0);
    check_output("coinc_ufcount", 32'(bus.underflow_count), 32'd3);
    pulse();
    expect_load("coinc_next", 10'h0F0);

    // Mode 2 alternates, falling back to the other source when the favoured one is empty
    bus.mode = 2'd2;
    offer_a(10'h011);
    offer_b(10'h021);
    pulse();
    expect_load("alt1_A", 10'h011);
    offer_a(10'h012);
    pulse();
    expect_load("alt2_B", 10'h021);
    offer_b(10'h022);
    pulse();
    expect_load("alt3_A", 10'h012);
    offer_a(10'h013);
    pulse();
    expect_load("alt4_B", 10'h022);
    pulse();
    expect_load("alt5_A", 10'h013);
    offer_b(10'h031);
    pulse();
    expect_load("altB1", 10'h031);
    offer_b(10'h032);
    pulse();
    expect_load("altB2", 10'h032);
    check_output("alt_ufcount", 32'(bus.underflow_count), 32'd3);

    // Mode 1 starving for 65537 windows saturates the counter
    bus.mode        = 2'd1;
    bus.next_sample = 1'b1;
    repeat (65537) tick();
    bus.next_sample = 1'b0;
    expect_starve("sat", 10'h032);
    check_output("sat_count", 32'(bus.underflow_count), 32'hFFFF);
    pulse();
    check_output("sat_hold", 32'(bus.underflow_count), 32'hFFFF);

    // Mid-window reset drops both buffered samples
    bus.mode = 2'd0;
    offer_a(10'h111);
    offer_b(10'h222);
    rst = 1'b1;
    tick();
    check_output("rst2_aready", 32'(bus.a_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_output("rst2_aready_after", 32'(bus.a_ready), 32'd1);
    check_output("rst2_bready_after", 32'(bus.b_ready), 32'd1);
    pulse();
    expect_starve("rst2_drop", 10'h000);
    check_output("rst2_ufcount", 32'(bus.underflow_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
